zion_basic_circuit_lib_clr_skid_reg: RTL and testbench
======================================================

Name: zion_basic_circuit_lib_clr_skid_reg

Overview:
- Two-entry valid/ready pipeline register (skid buffer) with synchronous flush.
- Breaks the combinational ready path between two pipeline stages; both oRdy and oVld come straight from flops.
- Sits directly upstream of the enable/clear DFF stage. Its accept condition drives that stage's enable, and its flush mirrors that stage's clear.

Parameters:
- WIDTH, 8, width of iDat/oDat.
- INI_DATA, '0, value loaded into both data registers on reset and on clear.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- iClr, input, 1, synchronous flush, active high.
- iVld, input, 1, upstream data valid.
- oRdy, output, 1, upstream may transfer; flop-driven.
- iDat, input, WIDTH, upstream data.
- oVld, output, 1, downstream data valid; flop-driven.
- iRdy, input, 1, downstream ready.
- oDat, output, WIDTH, downstream data (main register).
- oCnt, output, 2, occupancy 0..2.

Behaviour:
- Reset (rst low, asynchronous, active-low):
  - state EMPTY; main and skid registers = INI_DATA.
  - oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA.
- Definitions:
  - push = iVld & oRdy.
  - pop = oVld & iRdy.
- State machine, encoded so oVld = (state!=EMPTY), oRdy = (state!=FULL), oCnt = 0/1/2:
  - EMPTY:
    - push: main<=iDat, go to ONE.
    - no push: stay.
  - ONE:
    - push & !pop: skid<=iDat, go to FULL.
    - push & pop: main<=iDat, stay ONE.
    - !push & pop: go to EMPTY; main keeps its last value.
    - neither: hold.
  - FULL (oRdy=0, so push is impossible):
    - pop: main<=skid, go to ONE.
    - no pop: hold.
- Latency:
  - Data pushed into EMPTY appears on oDat/oVld on the next cycle (1-cycle latency).
  - Throughput is 1 beat/cycle when iRdy stays high.
- Ordering: strict FIFO order; no beat is dropped or duplicated.
- Stability: while oVld=1 and iRdy=0, oDat and oVld hold unchanged every cycle.
- Clear (iClr=1 at a clock edge, rst high):
  - Highest priority below reset; overrides any same-cycle push or pop.
  - Result: state EMPTY, main and skid = INI_DATA, oVld=0, oRdy=1, oCnt=0.
  - A beat offered in the clear cycle is discarded, even though oRdy was 1 during that cycle.
  - Upstream must treat a handshake in the clear cycle as dropped.
- Reset mid-transfer: contents are lost immediately and asynchronously. Outputs take reset values before the next edge.
- Skid register contents are undefined to the consumer; only main drives oDat.
- Assertions:
  - Bench assertion: oCnt never exceeds 2.
  - Assertion: iDat is X-free whenever push is true.

Test Plan:
- Reset then stream: rst low→high, iRdy=1, push 0x11,0x22,0x33 on consecutive cycles → oDat 0x11,0x22,0x33 one cycle later each, oVld high 3 cycles, oRdy stays 1, oCnt max 1.
- Backpressure fill: iRdy=0, push 0xA1 then 0xA2 → oCnt=2, oRdy=0 next cycle, oDat holds 0xA1. Raise iRdy → 0xA1 then 0xA2 out, oRdy returns 1 after the first pop.
- Simultaneous push/pop in ONE: main=0x05, push 0x06 with iRdy=1 → 0x05 consumed, oDat=0x06, oCnt stays 1.
- Clear while FULL with iVld=1: iClr=1 for one cycle → oVld=0, oCnt=0, oDat=INI_DATA (e.g. 0x00), offered beat absent; next push 0x77 → appears normally.
- Async reset mid-FULL: drop rst between edges → oVld=0, oRdy=1, oCnt=0 immediately, with no clock edge required.
- Random iVld/iRdy for 10k cycles against a scoreboard → in-order, lossless delivery; oDat stable under stall.

Source files
------------

// File: rtl/zion_basic_circuit_lib_clr_skid_reg.sv
// Two-entry valid/ready skid register with synchronous flush.
// oRdy and oVld are both taken straight from flops. This breaks the
// combinational ready path between the upstream and downstream stages.
// Only the main register drives oDat. The skid register absorbs the one
// beat that arrives while the downstream stage is stalled.
module zion_basic_circuit_lib_clr_skid_reg #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oCnt
);

    // The state encoding is the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, stateNxt;
    logic [WIDTH-1:0] mainQ, mainNxt;
    logic [WIDTH-1:0] skidQ, skidNxt;
    logic             vldQ, rdyQ;
    logic             push, pop;

    // Handshakes are qualified by the registered flags, never by next-state logic.
    assign push = iVld & rdyQ;
    assign pop  = vldQ & iRdy;

    // Next-state and datapath selection; clear overrides any same-cycle push/pop.
    always_comb begin
        stateNxt = state;
        mainNxt  = mainQ;
        skidNxt  = skidQ;
        if (iClr) begin
            stateNxt = EMPTY;
            mainNxt  = INI_DATA;
            skidNxt  = INI_DATA;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        mainNxt  = iDat;
                        stateNxt = ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skidNxt  = iDat;
                        stateNxt = FULL;
                    end else if (push && pop) begin
                        mainNxt  = iDat;
                    end else if (!push && pop) begin
                        // main keeps the beat just consumed; only oVld drops
                        stateNxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        mainNxt  = skidQ;
                        stateNxt = ONE;
                    end
                end
                default: begin
                    // unreachable encoding: recover to a clean empty buffer
                    stateNxt = EMPTY;
                    mainNxt  = INI_DATA;
                    skidNxt  = INI_DATA;
                end
            endcase
        end
    end

    // State, data and the registered handshake flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            mainQ <= INI_DATA;
            skidQ <= INI_DATA;
            vldQ  <= 1'b0;
            rdyQ  <= 1'b1;
        end else begin
            state <= stateNxt;
            mainQ <= mainNxt;
            skidQ <= skidNxt;
            vldQ  <= (stateNxt != EMPTY);
            rdyQ  <= (stateNxt != FULL);
        end
    end

    assign oVld = vldQ;
    assign oRdy = rdyQ;
    assign oDat = mainQ;
    assign oCnt = state;

`ifndef SYNTHESIS
    // Accepted data must be fully defined.
    a_dat_known: assert property (@(posedge clk) disable iff (!rst)
        push |-> !$isunknown(iDat));
`endif

endmodule

// File: tb/tb_zion_basic_circuit_lib_clr_skid_reg.sv
// Randomized bench for the clearable skid register.
// A queue-based FIFO model predicts every output after each clock edge.
module tb_zion_basic_circuit_lib_clr_skid_reg;

    localparam int         WIDTH    = 8;
    localparam logic [7:0] INI_DATA = 8'h00;

    logic             clk = 1'b0;
    logic             rst;
    logic             iClr, iVld, iRdy;
    logic [WIDTH-1:0] iDat;
    logic             oRdy, oVld;
    logic [WIDTH-1:0] oDat;
    logic [1:0]       oCnt;

    int checks = 0;
    int errors = 0;

    // model: queue of beats held; lastDat = value sitting in the output register
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] lastDat;
    int               delivered = 0;

    zion_basic_circuit_lib_clr_skid_reg #(.WIDTH(WIDTH), .INI_DATA(INI_DATA)) dut (
        .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(oRdy),
        .iDat(iDat), .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oCnt(oCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        lastDat = INI_DATA;
    endtask

    // One clock edge of FIFO behaviour, using the inputs held across the edge.
    task automatic modelStep();
        bit canPush, canPop;
        if (!rst || iClr) begin
            modelReset();
        end else begin
            canPush = iVld && (q.size() < 2);
            canPop  = iRdy && (q.size() > 0);
            if (canPop) begin
                void'(q.pop_front());
                delivered++;
            end
            if (canPush) q.push_back(iDat);
            if (q.size() > 0) lastDat = q[0];
        end
    endtask

    task automatic checkOut();
        chk("vld", oVld, q.size() > 0);
        chk("rdy", oRdy, q.size() < 2);
        chk("cnt", oCnt, q.size());
        chk("dat", oDat, lastDat);
        chk("cntMax", oCnt <= 2'd2, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
        checkOut();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        iVld = v; iDat = d; iRdy = r; iClr = c;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 8'h00, 0, 0);
        modelReset();
        #12;
        chk("rstVld", oVld, 0);
        chk("rstRdy", oRdy, 1);
        chk("rstCnt", oCnt, 0);
        chk("rstDat", oDat, INI_DATA);
        rst = 1'b1;

        // stream with iRdy high
        drive(1, 8'h11, 1, 0); tick(); chk("s11", oDat, 8'h11);
        drive(1, 8'h22, 1, 0); tick(); chk("s22", oDat, 8'h22);
        drive(1, 8'h33, 1, 0); tick(); chk("s33", oDat, 8'h33); chk("sCnt", oCnt, 1);
        drive(0, 8'h00, 1, 0); tick(); chk("sEnd", oVld, 0);

        // backpressure fill, then drain
        drive(1, 8'hA1, 0, 0); tick();
        drive(1, 8'hA2, 0, 0); tick();
        chk("bpCnt", oCnt, 2); chk("bpRdy", oRdy, 0); chk("bpDat", oDat, 8'hA1);
        drive(0, 8'h00, 1, 0); tick();
        chk("bpA2", oDat, 8'hA2); chk("bpRdy1", oRdy, 1);
        tick(); chk("bpEmpty", oVld, 0);

        // simultaneous push and pop in ONE
        drive(1, 8'h05, 0, 0); tick();
        drive(1, 8'h06, 1, 0); tick();
        chk("ppDat", oDat, 8'h06); chk("ppCnt", oCnt, 1);
        drive(0, 8'h00, 1, 0); tick();

        // clear while FULL with a beat offered
        drive(1, 8'h10, 0, 0); tick();
        drive(1, 8'h20, 0, 0); tick();
        drive(1, 8'h99, 0, 1); tick();
        chk("clrVld", oVld, 0); chk("clrCnt", oCnt, 0); chk("clrDat", oDat, INI_DATA);
        drive(1, 8'h77, 0, 0); tick();
        chk("clr77", oDat, 8'h77); chk("clrV77", oVld, 1);
        drive(0, 8'h00, 1, 0); tick();

        // async reset mid-FULL, between edges
        drive(1, 8'h44, 0, 0); tick();
        drive(1, 8'h55, 0, 0); tick();
        drive(0, 8'h00, 0, 0);
        #3 rst = 1'b0;
        #1;
        modelReset();
        chk("arVld", oVld, 0); chk("arRdy", oRdy, 1);
        chk("arCnt", oCnt, 0); chk("arDat", oDat, INI_DATA);
        tick();
        #2 rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 63) == 0);
            tick();
        end
        drive(0, 8'h00, 1, 0);
        tick(); tick();
        chk("drained", oVld, 0);
        chk("traffic", delivered > 1000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
